// File: rtl/dec_pkg.sv
// Shared decode definitions: immediate-mode encodings, instruction field positions
// and default widths used by dec_stage_gen and dec_regfile.
package dec_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREG  = 32;
    localparam int DEF_RA_W  = 5;
    localparam int DEF_IMM_W = 16;

    // Register fields are fixed at 5 bits in the instruction word.
    localparam int FIELD_W = 5;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;

    typedef enum logic [1:0] {
        IMM_SEXT     = 2'b00,
        IMM_ZEXT     = 2'b01,
        IMM_UPPER    = 2'b10,
        IMM_ZEXT_ALT = 2'b11
    } imm_mode_e;

endpackage

// File: rtl/dec_regfile.sv
// Architectural register file: NREG x XLEN, two async read ports, one sync write port,
// synchronous active-low clear; register 0 and out-of-range addresses read as zero.
module dec_regfile
    import dec_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int RA_W = DEF_RA_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [RA_W-1:0] i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [RA_W-1:0] i_raddr_a,
    input  logic [RA_W-1:0] i_raddr_b,
    output logic [XLEN-1:0] o_rdata_a,
    output logic [XLEN-1:0] o_rdata_b
);

    logic [XLEN-1:0] r_mem [NREG];
    logic            w_we_ok;

    function automatic logic addr_ok(input logic [RA_W-1:0] a);
        return (a != '0) && (int'(a) < NREG);
    endfunction

    assign w_we_ok = i_we && addr_ok(i_waddr);

    // NOTE: the memory is cleared on reset because software relies on all registers
    // reading zero afterwards; a storage array would normally be left unreset.
    // NOTE: non-blocking assignments here keep every register update in the same
    // edge-ordered evaluation, so readers in other blocks see the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = addr_ok(i_raddr_a) ? r_mem[i_raddr_a] : '0;
    assign o_rdata_b = addr_ok(i_raddr_b) ? r_mem[i_raddr_b] : '0;

endmodule

// File: rtl/dec_stage_gen.sv
// Decode stage: register-file read, immediate extension and a single-entry valid/ready
// output register with stall and flush. Optional write-through bypass: DEC_STAGE_BYPASS_EN.
module dec_stage_gen
    import dec_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREG  = DEF_NREG,
    parameter int RA_W  = DEF_RA_W,
    parameter int IMM_W = DEF_IMM_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [1:0]      imm_mode,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] reg_a,
    output logic [XLEN-1:0] reg_b,
    output logic [XLEN-1:0] imm_ext,
    output logic [RA_W-1:0] rd_addr,
    input  logic            wb_en,
    input  logic [RA_W-1:0] wb_addr,
    input  logic [XLEN-1:0] wb_data
);

    logic            r_valid;
    logic [XLEN-1:0] r_reg_a;
    logic [XLEN-1:0] r_reg_b;
    logic [XLEN-1:0] r_imm_ext;
    logic [RA_W-1:0] r_rd_addr;

    logic [RA_W-1:0]  w_rs;
    logic [RA_W-1:0]  w_rt;
    logic [RA_W-1:0]  w_rd;
    logic [IMM_W-1:0] w_imm;
    logic [XLEN-1:0]  w_rf_a;
    logic [XLEN-1:0]  w_rf_b;
    logic [XLEN-1:0]  w_op_a;
    logic [XLEN-1:0]  w_op_b;
    logic [XLEN-1:0]  w_imm_ext;
    logic             w_accept;

    assign w_rs  = RA_W'(instr[RS_LSB +: FIELD_W]);
    assign w_rt  = RA_W'(instr[RT_LSB +: FIELD_W]);
    assign w_rd  = RA_W'(instr[RD_LSB +: FIELD_W]);
    assign w_imm = instr[IMM_W-1:0];

    dec_regfile #(
        .XLEN (XLEN),
        .NREG (NREG),
        .RA_W (RA_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (wb_en),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rf_a),
        .o_rdata_b (w_rf_b)
    );

`ifdef DEC_STAGE_BYPASS_EN
    assign w_op_a = (wb_en && wb_addr == w_rs && wb_addr != '0) ? wb_data : w_rf_a;
    assign w_op_b = (wb_en && wb_addr == w_rt && wb_addr != '0) ? wb_data : w_rf_b;
`else
    assign w_op_a = w_rf_a;
    assign w_op_b = w_rf_b;
`endif

    // NOTE: assigning a default before the case keeps this block purely combinational;
    // any path that leaves w_imm_ext unassigned would infer a latch.
    always_comb begin
        w_imm_ext = XLEN'(w_imm);
        case (imm_mode)
            IMM_SEXT:  w_imm_ext = XLEN'($signed(w_imm));
            IMM_UPPER: w_imm_ext = XLEN'(w_imm) << (XLEN - IMM_W);
            default:   w_imm_ext = XLEN'(w_imm);
        endcase
    end

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_reg_a   <= '0;
            r_reg_b   <= '0;
            r_imm_ext <= '0;
            r_rd_addr <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (in_ready) begin
                r_valid <= in_valid;
            end
            // Payload only moves on a real accept so a drained bundle stays visible.
            if (w_accept) begin
                r_reg_a   <= w_op_a;
                r_reg_b   <= w_op_b;
                r_imm_ext <= w_imm_ext;
                r_rd_addr <= w_rd;
            end
        end
    end

    assign out_valid = r_valid;
    assign reg_a     = r_reg_a;
    assign reg_b     = r_reg_b;
    assign imm_ext   = r_imm_ext;
    assign rd_addr   = r_rd_addr;

endmodule

// File: tb/tb_dec_stage_gen.sv
// Scoreboard bench for dec_stage_gen: directed stimulus pushes expected bundles,
// a negedge monitor pops and compares every bundle the DUT hands to execute.
module tb_dec_stage_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [1:0]  imm_mode;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [31:0] imm_ext;
    logic [4:0]  rd_addr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef DEC_STAGE_BYPASS_EN
    localparam logic [31:0] SAME_CYCLE_A = 32'h0000_0055;
`else
    localparam logic [31:0] SAME_CYCLE_A = 32'h0000_0011;
`endif

    dec_stage_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .imm_mode  (imm_mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .imm_ext   (imm_ext),
        .rd_addr   (rd_addr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        tick();
        wb_en   = 1'b0;
    endtask

    // rd occupies instr[15:11], which overlaps the 16-bit immediate, so the
    // expected rd is hand-derived from the immediate's top five bits.
    task automatic send(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                        input logic [1:0] mode, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] ei, input logic [4:0] erd, input bit push);
        in_valid = 1'b1;
        instr    = {6'b0, rs, rt, imm};
        imm_mode = mode;
        for (int n = 0; n < 20; n++) begin
            if (in_ready) begin
                if (push) q.push_back('{a: ea, b: eb, imm: ei, rd: erd});
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        errors++;
        checks++;
        $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_bundle: got reg_a=%h rd=%0d, required none", reg_a, rd_addr);
                end else begin
                    e = q.pop_front();
                    check("bundle_reg_a", reg_a, e.a);
                    check("bundle_reg_b", reg_b, e.b);
                    check("bundle_imm_ext", imm_ext, e.imm);
                    check("bundle_rd_addr", 32'(rd_addr), 32'(e.rd));
                end
            end
        end
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; instr = '0; imm_mode = '0; flush = 1'b0;
        out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        tick(); tick();
        rst = 1'b1;

        // Reset: preload R5, make outputs non-zero, then reset with an accept pending.
        wb_write(5'd5, 32'h0000_1234);
        send(5'd5, 5'd5, 16'h1234, 2'b00, 32'h1234, 32'h1234, 32'h0000_1234, 5'd2, 1'b1);
        tick();
        rst = 1'b0; in_valid = 1'b1; instr = {6'b0, 5'd5, 5'd5, 16'h4801};
        tick();
        in_valid = 1'b0; rst = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_reg_a", reg_a, 32'd0);
        check("rst_reg_b", reg_b, 32'd0);
        check("rst_imm_ext", imm_ext, 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        send(5'd5, 5'd0, 16'h0000, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b1);

        // Basic decode and all immediate modes, issued back to back.
        wb_write(5'd3, 32'hDEAD_BEEF);
        wb_write(5'd4, 32'h0000_0007);
        send(5'd3, 5'd4, 16'h8001, 2'b00, 32'hDEAD_BEEF, 32'd7, 32'hFFFF_8001, 5'd16, 1'b1);
        send(5'd0, 5'd3, 16'h8001, 2'b01, 32'd0, 32'hDEAD_BEEF, 32'h0000_8001, 5'd16, 1'b1);
        send(5'd4, 5'd4, 16'h8001, 2'b10, 32'd7, 32'd7, 32'h8001_0000, 5'd16, 1'b1);
        send(5'd3, 5'd0, 16'h8001, 2'b11, 32'hDEAD_BEEF, 32'd0, 32'h0000_8001, 5'd16, 1'b1);
        send(5'd4, 5'd3, 16'h4801, 2'b00, 32'd7, 32'hDEAD_BEEF, 32'h0000_4801, 5'd9, 1'b1);
        tick();
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: bundle A held for three cycles while B waits.
        out_ready = 1'b0;
        send(5'd3, 5'd4, 16'h00FF, 2'b01, 32'hDEAD_BEEF, 32'd7, 32'h0000_00FF, 5'd0, 1'b1);
        in_valid = 1'b1; instr = {6'b0, 5'd4, 5'd3, 16'h7FFF}; imm_mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_reg_a", reg_a, 32'hDEAD_BEEF);
            check("hold_imm_ext", imm_ext, 32'h0000_00FF);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        q.push_back('{a: 32'd7, b: 32'hDEAD_BEEF, imm: 32'h0000_7FFF, rd: 5'd15});
        tick();
        send(5'd0, 5'd4, 16'hF800, 2'b00, 32'd0, 32'd7, 32'hFFFF_F800, 5'd31, 1'b1);
        tick();

        // Flush with a simultaneous accept: nothing may be emitted.
        in_valid = 1'b1; instr = {6'b0, 5'd3, 5'd3, 16'h1111}; flush = 1'b1;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_accept_out_valid", 32'(out_valid), 32'd0);

        // Flush a bundle that is being held by execute.
        out_ready = 1'b0;
        send(5'd3, 5'd3, 16'h2222, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        check("held_out_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b1;
        check("flush_held_out_valid", 32'(out_valid), 32'd0);

        // R0 stays zero after a write.
        wb_write(5'd0, 32'hFFFF_FFFF);
        send(5'd0, 5'd0, 16'h0000, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b1);

        // Same-cycle write-back and read of R6.
        wb_write(5'd6, 32'h0000_0011);
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h0000_0055;
        send(5'd6, 5'd6, 16'h0002, 2'b01, SAME_CYCLE_A, SAME_CYCLE_A, 32'h0000_0002, 5'd0, 1'b1);
        wb_en = 1'b0;
        send(5'd6, 5'd0, 16'h0003, 2'b01, 32'h0000_0055, 32'd0, 32'h0000_0003, 5'd0, 1'b1);
        tick(); tick();

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
